// File: rtl/mm_pkg.sv
// ----------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the 2x2 matrix-multiplier datapath.
//   MM_N   : default matrix dimension (one matrix = MM_N*MM_N elements)
//   MM_W   : default element width, equal to the multiplier result width
//   idx_w  : width needed to index n positions, never less than one bit
// ----------------------------------------------------------------------------
package mm_pkg;

   localparam int MM_N = 2;
   localparam int MM_W = 17;

   // A one-bit floor keeps degenerate sizes (n <= 1) from producing
   // zero-width vectors.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mm_pingpong_buf.sv
// ----------------------------------------------------------------------------
// mm_pingpong_buf
// Two-bank element store for the result collector. Each bank holds one
// N x N matrix. One write port and one asynchronous read mux, so the
// collector can present the addressed element in the same cycle its read
// pointer changes. Contents are not reset.
// Ports:
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_bank_i  : bank selected for writing
//   wr_addr_i  : element index inside the write bank (row-major)
//   wr_data_i  : element to store
//   rd_bank_i  : bank selected for reading
//   rd_addr_i  : element index inside the read bank
//   rd_data_o  : element at {rd_bank_i, rd_addr_i}
// ----------------------------------------------------------------------------
module mm_pingpong_buf
   import mm_pkg::*;
#(
   parameter int N     = MM_N,
   parameter int W     = MM_W,
   parameter int CNT_W = idx_w(N * N)
) (
   input  logic             clk,
   input  logic             wr_en_i,
   input  logic             wr_bank_i,
   input  logic [CNT_W-1:0] wr_addr_i,
   input  logic [W-1:0]     wr_data_i,
   input  logic             rd_bank_i,
   input  logic [CNT_W-1:0] rd_addr_i,
   output logic [W-1:0]     rd_data_o
);

   localparam int NN = N * N;

   // Word currently addressed by the read pointer in each bank.
   logic [W-1:0] bank_rd [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         logic [W-1:0] mem_q [NN];

         always_ff @(posedge clk) begin
            if (wr_en_i && (wr_bank_i == 1'(gi))) begin
               mem_q[wr_addr_i] <= wr_data_i;
            end
         end

         assign bank_rd[gi] = mem_q[rd_addr_i];
      end
   endgenerate

   assign rd_data_o = bank_rd[rd_bank_i];

endmodule

// File: rtl/mm_result_collector.sv
// ----------------------------------------------------------------------------
// mm_result_collector
// Gathers result elements from the matrix multiplier into ping-pong banks
// (row-major, N*N elements per matrix) and streams finished matrices out
// over valid/ready, so collecting one matrix overlaps draining the other.
// Ports:
//   CLK        : clock, all state on the rising edge
//   RST        : synchronous active-high reset
//   IN_DATA    : element from the multiplier
//   IN_STROBE  : IN_DATA valid this cycle (no backpressure upstream)
//   OUT_DATA   : element being offered
//   OUT_ROW    : row index of OUT_DATA
//   OUT_COL    : column index of OUT_DATA
//   OUT_LAST   : OUT_DATA is the final element of its matrix
//   OUT_VALID  : an element is offered
//   OUT_READY  : consumer takes the element this cycle
//   OVERFLOW   : sticky, an incoming element had nowhere to go
// ----------------------------------------------------------------------------
module mm_result_collector
   import mm_pkg::*;
#(
   parameter int N  = MM_N,
   parameter int W  = MM_W,
   parameter int IW = idx_w(N)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [W-1:0]  IN_DATA,
   input  logic          IN_STROBE,
   output logic [W-1:0]  OUT_DATA,
   output logic [IW-1:0] OUT_ROW,
   output logic [IW-1:0] OUT_COL,
   output logic          OUT_LAST,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic          OVERFLOW
);

   localparam int               CNT_W    = idx_w(N * N);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N * N - 1);
   localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);

   // Registered state
   logic [1:0]       bank_full_q, bank_full_d;
   logic             wr_bank_q,   wr_bank_d;
   logic [CNT_W-1:0] wr_cnt_q,    wr_cnt_d;
   logic             rd_bank_q,   rd_bank_d;
   logic [CNT_W-1:0] rd_cnt_q,    rd_cnt_d;
   logic             overflow_q,  overflow_d;

   // Handshake / acceptance decode
   logic out_valid;
   logic rd_fire;
   logic rd_last;
   logic rd_free;
   logic wr_accept;
   logic wr_last;

   assign out_valid = bank_full_q[rd_bank_q];
   assign rd_fire   = out_valid && OUT_READY;
   assign rd_last   = (rd_cnt_q == LAST_IDX);
   assign rd_free   = rd_fire && rd_last;

   // A full write bank may still take the strobe when the final read of
   // that very bank happens in the same cycle; the slot is free at the edge.
   assign wr_accept = IN_STROBE && !RST &&
                      (!bank_full_q[wr_bank_q] || (rd_free && (rd_bank_q == wr_bank_q)));
   assign wr_last   = (wr_cnt_q == LAST_IDX);

   always_comb begin
      bank_full_d = bank_full_q;
      wr_bank_d   = wr_bank_q;
      wr_cnt_d    = wr_cnt_q;
      rd_bank_d   = rd_bank_q;
      rd_cnt_d    = rd_cnt_q;
      overflow_d  = overflow_q;

      if (rd_fire) begin
         if (rd_last) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            rd_cnt_d               = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end

      // Applied after the read update so that a completing write into the
      // bank just freed leaves it marked full.
      if (wr_accept) begin
         if (wr_last) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
            wr_cnt_d               = '0;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end else if (IN_STROBE) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         bank_full_q <= '0;
         wr_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_bank_q   <= 1'b0;
         rd_cnt_q    <= '0;
         overflow_q  <= 1'b0;
      end else begin
         bank_full_q <= bank_full_d;
         wr_bank_q   <= wr_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_bank_q   <= rd_bank_d;
         rd_cnt_q    <= rd_cnt_d;
         overflow_q  <= overflow_d;
      end
   end

   mm_pingpong_buf #(
      .N     (N),
      .W     (W),
      .CNT_W (CNT_W)
   ) u_buf (
      .clk       (CLK),
      .wr_en_i   (wr_accept),
      .wr_bank_i (wr_bank_q),
      .wr_addr_i (wr_cnt_q),
      .wr_data_i (IN_DATA),
      .rd_bank_i (rd_bank_q),
      .rd_addr_i (rd_cnt_q),
      .rd_data_o (OUT_DATA)
   );

   // Outputs depend only on registered pointers/flags plus the read mux.
   assign OUT_VALID = out_valid;
   assign OUT_LAST  = rd_last;
   assign OUT_ROW   = IW'(rd_cnt_q / N_CNT);
   assign OUT_COL   = IW'(rd_cnt_q % N_CNT);
   assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_mm_result_collector.sv
// ----------------------------------------------------------------------------
// tb_mm_result_collector
// Lock-step bench: inputs are driven after the falling edge, the reference
// model advances at the rising edge, and outputs are compared at the next
// falling edge. The model holds completed matrices as a flat element queue
// plus a partially collected matrix, and decides acceptance by counting
// stored matrices.
// ----------------------------------------------------------------------------
module tb_mm_result_collector;

   localparam int N  = 2;
   localparam int W  = 17;
   localparam int IW = (N <= 1) ? 1 : $clog2(N);
   localparam int NN = N * N;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [W-1:0]  IN_DATA = '0;
   logic          IN_STROBE = 1'b0;
   logic [W-1:0]  OUT_DATA;
   logic [IW-1:0] OUT_ROW;
   logic [IW-1:0] OUT_COL;
   logic          OUT_LAST;
   logic          OUT_VALID;
   logic          OUT_READY = 1'b0;
   logic          OVERFLOW;

   always #5 CLK = ~CLK;

   mm_result_collector #(.N(N), .W(W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_DATA   (IN_DATA),
      .IN_STROBE (IN_STROBE),
      .OUT_DATA  (OUT_DATA),
      .OUT_ROW   (OUT_ROW),
      .OUT_COL   (OUT_COL),
      .OUT_LAST  (OUT_LAST),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OVERFLOW  (OVERFLOW)
   );

   int checks = 0;
   int errors = 0;

   // Reference model
   logic [W-1:0] done_q[$];     // completed, not yet consumed elements
   logic [W-1:0] partial_q[$];  // matrix under collection
   int           head_pos = 0;  // elements already consumed from head matrix
   logic         m_ovf = 1'b0;

   logic          exp_valid;
   logic [W-1:0]  exp_data;
   logic [IW-1:0] exp_row;
   logic [IW-1:0] exp_col;
   logic          exp_last;

   task automatic refresh_exp();
      exp_valid = (done_q.size() > 0);
      exp_data  = exp_valid ? done_q[0] : '0;
      exp_row   = IW'(head_pos / N);
      exp_col   = IW'(head_pos % N);
      exp_last  = (head_pos == NN - 1);
   endtask

   task automatic do_reset(input logic s, input logic [W-1:0] d);
      RST = 1'b1; IN_STROBE = s; IN_DATA = d; OUT_READY = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0; IN_STROBE = 1'b0;
      done_q.delete(); partial_q.delete(); head_pos = 0; m_ovf = 1'b0;
      refresh_exp();
   endtask

   // One clock of stimulus; model decisions are taken from pre-edge state.
   task automatic step(input logic s, input logic [W-1:0] d, input logic r);
      bit fire, fin, acc;
      int held;
      IN_STROBE = s; IN_DATA = d; OUT_READY = r;
      held = (done_q.size() + head_pos) / NN;
      fire = (done_q.size() > 0) && r;
      fin  = fire && (head_pos == NN - 1);
      acc  = s && ((held < 2) || fin);
      @(posedge CLK);
      if (fire) begin
         void'(done_q.pop_front());
         head_pos = fin ? 0 : head_pos + 1;
      end
      if (acc) begin
         partial_q.push_back(d);
         if (partial_q.size() == NN) begin
            foreach (partial_q[k]) done_q.push_back(partial_q[k]);
            partial_q.delete();
         end
      end else if (s) begin
         m_ovf = 1'b1;
      end
      @(negedge CLK);
      IN_STROBE = 1'b0;
      refresh_exp();
   endtask

   task automatic test_reset();
      do_reset(1'b0, '0);
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset valid: got %b exp 0", OUT_VALID); end
      checks++; if (OUT_LAST !== 1'b0) begin errors++; $display("FAIL reset last: got %b exp 0", OUT_LAST); end
      checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b exp 0", OVERFLOW); end
      checks++; if (OUT_ROW !== '0 || OUT_COL !== '0) begin errors++; $display("FAIL reset idx: got r=%0d c=%0d exp 0 0", OUT_ROW, OUT_COL); end
      $display("reset: valid=%b last=%b ovf=%b", OUT_VALID, OUT_LAST, OVERFLOW);
   endtask

   task automatic test_single_matrix();
      int lasts = 0;
      do_reset(1'b0, '0);
      for (int c = 0; c < 9; c++) begin
         step(c < NN, W'(c + 1), 1'b1);
         checks++; if (OUT_VALID !== exp_valid) begin errors++; $display("FAIL single valid c%0d: got %b exp %b", c, OUT_VALID, exp_valid); end
         if (exp_valid) begin
            checks++;
            if (OUT_DATA !== exp_data || OUT_ROW !== exp_row || OUT_COL !== exp_col || OUT_LAST !== exp_last) begin
               errors++;
               $display("FAIL single elem c%0d: got d=%0h r=%0d c=%0d l=%b exp d=%0h r=%0d c=%0d l=%b", c, OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST, exp_data, exp_row, exp_col, exp_last);
            end
            if (OUT_LAST) lasts++;
            $display("single xfer d=%0d row=%0d col=%0d last=%b", OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST);
         end
         checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL single overflow c%0d: got %b exp 0", c, OVERFLOW); end
      end
      checks++; if (lasts != 1) begin errors++; $display("FAIL single last count: got %0d exp 1", lasts); end
   endtask

   task automatic test_backpressure_overflow();
      do_reset(1'b0, '0);
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, W'(k), 1'b0);
         if (k >= NN) begin
            checks++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== W'(1)) begin
               errors++; $display("FAIL bp hold k%0d: got v=%b d=%0h exp v=1 d=1", k, OUT_VALID, OUT_DATA);
            end
         end
      end
      step(1'b1, W'(9), 1'b0);
      checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL bp overflow: got %b exp 1", OVERFLOW); end
      $display("bp: strobe 9 dropped, ovf=%b", OVERFLOW);
      for (int k = 1; k <= 8; k++) begin
         checks++;
         if (OUT_VALID !== 1'b1 || OUT_DATA !== W'(k) || OUT_DATA !== exp_data) begin
            errors++; $display("FAIL bp drain k%0d: got v=%b d=%0h exp v=1 d=%0h", k, OUT_VALID, OUT_DATA, k);
         end
         $display("bp xfer d=%0d row=%0d col=%0d last=%b", OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST);
         step(1'b0, '0, 1'b1);
      end
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL bp empty: got %b exp 0", OUT_VALID); end
   endtask

   task automatic test_same_cycle();
      logic [W-1:0] want[$];
      do_reset(1'b0, '0);
      for (int k = 1; k <= 8; k++) step(1'b1, W'(k), 1'b0);
      for (int k = 0; k < NN - 1; k++) step(1'b0, '0, 1'b1);
      // final read of bank 0 coincides with strobe 10
      step(1'b1, W'(10), 1'b1);
      checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL same ovf: got %b exp 0", OVERFLOW); end
      for (int k = 11; k <= 13; k++) step(1'b1, W'(k), 1'b1);
      want = '{W'(8), W'(10), W'(11), W'(12), W'(13)};
      foreach (want[i]) begin
         checks++;
         if (OUT_VALID !== 1'b1 || OUT_DATA !== want[i] || OUT_DATA !== exp_data) begin
            errors++; $display("FAIL same seq %0d: got v=%b d=%0h exp d=%0h", i, OUT_VALID, OUT_DATA, want[i]);
         end
         $display("same xfer d=%0d row=%0d col=%0d last=%b", OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST);
         step(1'b0, '0, 1'b1);
      end
      checks++; if (OUT_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin errors++; $display("FAIL same end: got v=%b o=%b exp 0 0", OUT_VALID, OVERFLOW); end
   endtask

   task automatic test_stall();
      logic rdy[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [W-1:0]  hold_d;
      logic [IW-1:0] hold_r, hold_c;
      do_reset(1'b0, '0);
      for (int k = 1; k <= NN; k++) step(1'b1, W'(k + 20), 1'b0);
      foreach (rdy[c]) begin
         hold_d = OUT_DATA; hold_r = OUT_ROW; hold_c = OUT_COL;
         step(1'b0, '0, rdy[c]);
         if (!rdy[c]) begin
            checks++;
            if (OUT_DATA !== hold_d || OUT_ROW !== hold_r || OUT_COL !== hold_c) begin
               errors++; $display("FAIL stall hold c%0d: got d=%0h r=%0d c=%0d exp d=%0h r=%0d c=%0d", c, OUT_DATA, OUT_ROW, OUT_COL, hold_d, hold_r, hold_c);
            end
         end
         checks++; if (OUT_VALID !== exp_valid) begin errors++; $display("FAIL stall valid c%0d: got %b exp %b", c, OUT_VALID, exp_valid); end
         if (exp_valid) begin
            checks++;
            if (OUT_DATA !== exp_data || OUT_ROW !== exp_row || OUT_COL !== exp_col || OUT_LAST !== exp_last) begin
               errors++;
               $display("FAIL stall elem c%0d: got d=%0h r=%0d c=%0d l=%b exp d=%0h r=%0d c=%0d l=%b", c, OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST, exp_data, exp_row, exp_col, exp_last);
            end
         end
         $display("stall c%0d ready=%b v=%b d=%0d", c, rdy[c], OUT_VALID, OUT_DATA);
      end
   endtask

   task automatic test_mid_reset();
      logic [W-1:0] vec[4] = '{17'h1FFFF, 17'h0, 17'h1FFFF, 17'h1};
      do_reset(1'b0, '0);
      for (int k = 1; k <= NN + 2; k++) step(1'b1, W'(k), 1'b0);
      do_reset(1'b1, W'(77));  // strobe during reset is ignored
      checks++; if (OUT_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin errors++; $display("FAIL midrst state: got v=%b o=%b exp 0 0", OUT_VALID, OVERFLOW); end
      foreach (vec[k]) step(1'b1, vec[k], 1'b0);
      foreach (vec[k]) begin
         checks++;
         if (OUT_VALID !== 1'b1 || OUT_DATA !== vec[k] || OUT_DATA !== exp_data || OUT_ROW !== IW'(k / N) || OUT_COL !== IW'(k % N)) begin
            errors++; $display("FAIL midrst elem %0d: got v=%b d=%0h r=%0d c=%0d exp d=%0h", k, OUT_VALID, OUT_DATA, OUT_ROW, OUT_COL, vec[k]);
         end
         $display("midrst xfer d=%0h row=%0d col=%0d last=%b", OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST);
         step(1'b0, '0, 1'b1);
      end
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL midrst empty: got %b exp 0", OUT_VALID); end
   endtask

   task automatic test_random();
      int xfers = 0;
      do_reset(1'b0, '0);
      for (int c = 0; c < 1200; c++) begin
         if (c % 300 == 299) do_reset(1'($urandom_range(0, 1)), W'($urandom));
         step(($urandom_range(0, 99) < 55), W'($urandom), ($urandom_range(0, 99) < ((c / 100) % 2 ? 80 : 40)));
         checks++; if (OUT_VALID !== exp_valid) begin errors++; $display("FAIL rand valid c%0d: got %b exp %b", c, OUT_VALID, exp_valid); end
         if (exp_valid) begin
            checks++;
            if (OUT_DATA !== exp_data || OUT_ROW !== exp_row || OUT_COL !== exp_col || OUT_LAST !== exp_last) begin
               errors++;
               $display("FAIL rand elem c%0d: got d=%0h r=%0d c=%0d l=%b exp d=%0h r=%0d c=%0d l=%b", c, OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST, exp_data, exp_row, exp_col, exp_last);
            end
            if (OUT_READY) xfers++;
         end
         checks++; if (OVERFLOW !== m_ovf) begin errors++; $display("FAIL rand overflow c%0d: got %b exp %b", c, OVERFLOW, m_ovf); end
      end
      $display("random: 1200 cycles, %0d offered-and-ready cycles", xfers);
   endtask

   initial begin
      test_reset();
      test_single_matrix();
      test_backpressure_overflow();
      test_same_cycle();
      test_stall();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
